// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by fifo_reader and its buffer.
//   DATA_WIDTH_DEF        default word width of the reader datapath
//   ST_IDLE/ST_RUN/ST_FLUSH  2-bit FSM state codes of fifo_reader
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry in-order buffer with simultaneous write and read.
//   clk, reset  clock, synchronous active-high reset
//   wr, wdata   write wdata at the tail
//   rd          pop the head entry (ignored when empty)
//   rdata       head entry (entry 0)
//   count       occupied entries, 0..2
module skid_buf2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        base;   // occupancy after the read, i.e. the write slot
  logic              do_wr;

  always_comb begin
    mem_d = mem_q;
    base  = cnt_q;
    // Read shifts entry 1 into the head before the write lands, so a
    // simultaneous read+write keeps the order intact.
    if (rd && cnt_q != 2'd0) begin
      mem_d[0] = mem_q[1];
      base     = cnt_q - 2'd1;
    end
    do_wr = wr && (base != 2'd2);
    if (do_wr) mem_d[base[0]] = wdata;
    cnt_d = base + {1'b0, do_wr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[0];
  assign count = cnt_q;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains an upstream FIFO (1-cycle read latency) into a
// valid/ready output stream through a 2-entry buffer.
//   clk, reset           clock, synchronous active-high reset
//   drain_en             run enable; low requests a graceful stop (FLUSH)
//   empty, data_out      upstream FIFO flag and read data
//   pop                  upstream pop request
//   out_valid/out_ready  output handshake, out_data is the buffer head
//   busy                 high in RUN or FLUSH
//   word_cnt             wrapping count of delivered words
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  drain_en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [31:0]           word_cnt
);

  logic [1:0]  state_q, state_d;
  logic        inflight_q, inflight_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [1:0]  held;
  logic        transfer;
  logic [2:0]  occ;

  skid_buf2 #(.W(DATA_WIDTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .wr    (inflight_q),
    .wdata (data_out),
    .rd    (transfer),
    .rdata (out_data),
    .count (held)
  );

  assign out_valid = (held != 2'd0);
  assign transfer  = out_valid && out_ready;

  // Slots committed next cycle: buffered + returning read - leaving word.
  // Popping only while this is below 2 keeps the buffer from overflowing.
  assign occ = {1'b0, held} + {2'b0, inflight_q} - {2'b0, transfer};
  assign pop = (state_q == ST_RUN) && !empty && (occ < 3'd2);

  assign busy     = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign word_cnt = word_cnt_q;

  always_comb begin
    state_d    = state_q;
    inflight_d = pop;
    word_cnt_d = word_cnt_q + {31'd0, transfer};
    case (state_q)
      ST_IDLE:  if (drain_en) state_d = ST_RUN;
      ST_RUN:   if (!drain_en) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (drain_en)                              state_d = ST_RUN;
        else if (held == 2'd0 && !inflight_q)      state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      word_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: fifo_reader against a depth-4 upstream FIFO model with
// 1-cycle read latency. Reference: an in-order queue of popped words, an
// occupancy/latency count of words sitting in the buffer, and a wrapping
// delivered-word counter.
module tb_fifo_reader;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, drain_en, empty, out_ready;
  logic [DW-1:0] data_out;
  logic          pop, out_valid, busy;
  logic [DW-1:0] out_data;
  logic [31:0]   word_cnt;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .drain_en  (drain_en),
    .empty     (empty),
    .data_out  (data_out),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  logic [DW-1:0] fifo_q[$];   // upstream FIFO contents
  logic [DW-1:0] sb[$];       // popped, not yet delivered, in order
  logic [DW-1:0] dq[$];       // delivered words
  logic [31:0]   wq[$];       // word_cnt right after each delivery
  int            dc[$];       // delivery cycle numbers
  int            n_chk = 0, n_fail = 0;
  int            avail = 0, infl = 0, pops = 0, cyc = 0;
  logic [31:0]   exp_cnt = 32'd0;
  logic [31:0]   w4 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    if (fifo_q.size() < 4) begin
      fifo_q.push_back(v);
      empty = 1'b0;
    end
  endtask

  // One clock: check outputs at negedge, then advance the models after the edge.
  task automatic tick();
    logic p, x, rs;
    logic [DW-1:0] d;
    @(negedge clk);
    p = pop; x = out_valid & out_ready; d = out_data; rs = reset;
    chk("out_valid", out_valid, avail > 0);
    chk("word_cnt", word_cnt, exp_cnt);
    chk("pop_when_empty", p & empty, 1'b0);
    if (x === 1'b1) begin
      chk("word_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) chk("word_order", d, sb.pop_front());
      dq.push_back(d);
      dc.push_back(cyc);
      exp_cnt = exp_cnt + 32'd1;
    end
    @(posedge clk); #1;
    cyc++;
    if (rs) begin
      sb.delete(); avail = 0; infl = 0; exp_cnt = 32'd0;
    end else begin
      avail = avail - ((x === 1'b1) ? 1 : 0) + infl;
      infl  = (p === 1'b1) ? 1 : 0;
    end
    if (p === 1'b1 && fifo_q.size() > 0) begin
      data_out = fifo_q.pop_front();
      if (!rs) sb.push_back(data_out);
      pops++;
    end
    empty = (fifo_q.size() == 0);
    chk("no_overflow", avail <= 2, 1'b1);
    if (x === 1'b1 && !rs) wq.push_back(word_cnt);
  endtask

  task automatic do_reset();
    drain_en = 1'b0; out_ready = 1'b0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    fifo_q.delete(); empty = 1'b1;
    dq.delete(); dc.delete(); wq.delete(); pops = 0;
  endtask

  initial begin
    int k;
    reset = 1'b1; drain_en = 1'b0; empty = 1'b1; out_ready = 1'b0; data_out = '0;
    @(posedge clk); #1;
    do_reset();
    chk("rst_pop", pop, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_word_cnt", word_cnt, 32'd0);
    chk("rst_out_data", out_data, 32'd0);

    // Streaming: 4 words on 4 consecutive cycles
    for (int i = 0; i < 4; i++) push(w4[i]);
    drain_en = 1'b1; out_ready = 1'b1;
    repeat (12) tick();
    chk("t1_count", dq.size(), 4);
    for (int i = 0; i < 4 && i < dq.size(); i++) chk("t1_word", dq[i], w4[i]);
    for (int i = 1; i < 4 && i < dc.size(); i++) chk("t1_gap", dc[i] - dc[i-1], 1);
    chk("t1_word_cnt", word_cnt, 32'd4);
    chk("t1_pop_idle", pop, 1'b0);

    // Backpressure: exactly two pops, head holds, then gapless drain
    do_reset();
    for (int i = 0; i < 4; i++) push(w4[i]);
    drain_en = 1'b1;
    repeat (10) begin
      tick();
      if (out_valid === 1'b1) chk("t2_hold", out_data, 32'h11);
    end
    chk("t2_stall_pops", pops, 2);
    chk("t2_stall_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    repeat (8) tick();
    chk("t2_count", dq.size(), 4);
    for (int i = 0; i < 4 && i < dq.size(); i++) chk("t2_word", dq[i], w4[i]);
    for (int i = 1; i < 4 && i < dc.size(); i++) chk("t2_gap", dc[i] - dc[i-1], 1);

    // Graceful stop with 2 words buffered
    do_reset();
    for (int i = 0; i < 4; i++) push(w4[i]);
    drain_en = 1'b1;
    repeat (5) tick();
    chk("t3_pre_pops", pops, 2);
    drain_en = 1'b0;
    tick(); tick();
    chk("t3_flush_busy", busy, 1'b1);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("t3_no_pop", pops, 2);
    chk("t3_count", dq.size(), 2);
    for (int i = 0; i < 2 && i < dq.size(); i++) chk("t3_word", dq[i], w4[i]);
    chk("t3_idle_busy", busy, 1'b0);
    chk("t3_fifo_left", fifo_q.size(), 2);
    if (fifo_q.size() == 2) begin
      chk("t3_fifo_w0", fifo_q[0], 32'h33);
      chk("t3_fifo_w1", fifo_q[1], 32'h44);
    end

    // Reset one cycle after a pop discards the returning word
    do_reset();
    push(32'hA1); push(32'hA2);
    drain_en = 1'b1; out_ready = 1'b1;
    k = 0;
    while (pops == 0 && k < 10) begin tick(); k++; end
    chk("t4_pop_seen", pops > 0, 1'b1);
    reset = 1'b1; drain_en = 1'b0;
    tick();
    reset = 1'b0;
    chk("t4_valid", out_valid, 1'b0);
    chk("t4_word_cnt", word_cnt, 32'd0);
    chk("t4_busy", busy, 1'b0);
    repeat (4) begin tick(); chk("t4_no_ghost", out_valid, 1'b0); end
    chk("t4_delivered", dq.size(), 0);

    // word_cnt wrap
    do_reset();
    push(32'hB1); push(32'hB2); push(32'hB3);
    drain_en = 1'b1; out_ready = 1'b1;
    force dut.word_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.word_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    repeat (10) tick();
    chk("t5_count", wq.size(), 3);
    if (wq.size() == 3) begin
      chk("t5_wc0", wq[0], 32'hFFFF_FFFF);
      chk("t5_wc1", wq[1], 32'h0000_0000);
      chk("t5_wc2", wq[2], 32'h0000_0001);
    end

    // Random traffic, backpressure and drain_en toggling
    do_reset();
    drain_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(1, 0) == 1) push($urandom);
      out_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) drain_en = ~drain_en;
      tick();
    end
    // Upstream empty toggling every cycle
    drain_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) push($urandom);
      tick();
    end
    k = 0;
    while ((fifo_q.size() != 0 || sb.size() != 0) && k < 50) begin tick(); k++; end
    chk("final_drained", sb.size() + fifo_q.size(), 0);
    drain_en = 1'b0;
    repeat (4) tick();
    chk("final_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the word width of the FIFO read data and of the output stream.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 drain_en  input  1  enables popping the upstream FIFO; low requests a graceful stop.
REQ-005 empty  input  1  upstream FIFO empty flag.
REQ-006 data_out  input  DATA_WIDTH  upstream FIFO read data, valid exactly 1 cycle after the pop cycle.
REQ-007 pop  output  1  pop request to the upstream FIFO.
REQ-008 out_valid  output  1  output word available.
REQ-009 out_data  output  DATA_WIDTH  output word (head of the internal buffer).
REQ-010 out_ready  input  1  downstream accepts the word when high together with out_valid.
REQ-011 busy  output  1  high in RUN or FLUSH.
REQ-012 word_cnt  output  32  count of words delivered downstream.

Function
REQ-013 Transfer occurs in a cycle when out_valid and out_ready are both high.
REQ-014 Internal 2-entry in-order buffer; held = number of occupied entries (0..2); inflight = pop registered from the previous cycle.
REQ-015 pop = (state==RUN) and !empty and (held + inflight - transfer) < 2; combinational from registered state and inputs.
REQ-016 On each cycle with inflight high, data_out is written to the buffer tail; a write and a transfer in the same cycle are both honoured.
REQ-017 out_valid = (held > 0); out_data = head entry; out_data holds stable while out_valid is high and out_ready is low.
REQ-018 Buffer never overflows: a write with held==2 and no transfer is impossible by construction; the bench asserts this.
REQ-019 Sustained throughput is 1 word/clk when !empty and out_ready are held high; first-word latency is 2 clk from pop (pop@t, write@t+1, out_valid@t+2 visible).
REQ-020 FSM states: IDLE, RUN, FLUSH.
REQ-021 IDLE -> RUN when drain_en is high.
REQ-022 RUN -> FLUSH when drain_en is low; no pop is issued in FLUSH.
REQ-023 FLUSH -> IDLE when held==0 and inflight==0; FLUSH -> RUN if drain_en returns high first.
REQ-024 In RUN, empty high suppresses pop only; the state stays RUN.
REQ-025 word_cnt increments by 1 on every transfer and wraps from 0xFFFFFFFF to 0.
REQ-026 Upstream empty toggling every cycle causes no loss, duplication or reordering of words.

Reset
REQ-027 While reset is high at a clock edge: state=IDLE, held=0, inflight=0, word_cnt=0.
REQ-028 After that edge: pop=0, out_valid=0, busy=0, word_cnt=0; out_data is don't-care (reset to 0).
REQ-029 Reset mid-transfer discards buffered and in-flight words; the FIFO data returned for a discarded pop is ignored.

Structure
REQ-030 FSM state encoding (IDLE=0, RUN=1, FLUSH=2, 2-bit) and DATA_WIDTH default belong in shared package fifo_pkg.
REQ-031 The 2-entry buffer is implemented as sub-module skid_buf2 (ports: clk, reset, wr, wdata, rd, rdata, count).

Verification
REQ-032 Bench instantiates fifo_reader connected to the existing fifo (DATA_WIDTH=32, depth 4) with a 100 MHz clk and 2-cycle reset; scoreboard compares pushed vs delivered words.
REQ-033 Push 0x11,0x22,0x33,0x44; drain_en=1, out_ready=1 -> out_data 0x11..0x44 on 4 consecutive cycles, word_cnt=4, pop low once empty.
REQ-034 FIFO full with 4 words; out_ready low 10 clk -> pop asserted exactly twice, out_data holds 0x11; then out_ready=1 -> all 4 words in order, no gaps after first.
REQ-035 drain_en dropped while 2 words buffered -> FLUSH, no further pop, both words delivered, then IDLE with busy=0; remaining FIFO contents untouched.
REQ-036 Reset asserted 1 cycle after a pop -> next cycle out_valid=0, word_cnt=0, state IDLE; the returned data never appears on out_data.
REQ-037 Preload word_cnt path via force to 0xFFFFFFFE, deliver 3 words -> word_cnt sequence 0xFFFFFFFF, 0x00000000, 0x00000001.
